// File: rtl/fetch_queue_if.sv
// Handshake and data bundle between the fetch side, the fetch queue and decode.
// slave: the queue itself. master: the fetch/decode environment driving it.
interface fetch_queue_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          flush_i;
   logic          fetch_valid_i;
   logic [31:0]   fetch_pc_i;
   logic [31:0]   fetch_instr_i;
   logic          fetch_ready_o;
   logic          dec_valid_o;
   logic [31:0]   dec_pc_o;
   logic [31:0]   dec_instr_o;
   logic          dec_misalign_o;
   logic          dec_ready_i;
   logic [CW-1:0] count_o;

   modport slave (
      input  flush_i,
      input  fetch_valid_i,
      input  fetch_pc_i,
      input  fetch_instr_i,
      output fetch_ready_o,
      output dec_valid_o,
      output dec_pc_o,
      output dec_instr_o,
      output dec_misalign_o,
      input  dec_ready_i,
      output count_o
   );

   modport master (
      output flush_i,
      output fetch_valid_i,
      output fetch_pc_i,
      output fetch_instr_i,
      input  fetch_ready_o,
      input  dec_valid_o,
      input  dec_pc_o,
      input  dec_instr_o,
      input  dec_misalign_o,
      output dec_ready_i,
      input  count_o
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {PC, instruction, misalign}
// between fetch and decode, with back-pressure to the PC and flush support.
// Optional feature macro: FETCHQ_BYPASS_EN (empty-queue combinational bypass).
module fetch_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   fetch_queue_if.slave  bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic        misalign;
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic   fetch_ready_c;
   logic   head_valid_c;
   logic   dec_valid_c;
   logic   push_c;
   logic   pop_c;
   entry_t in_c;
   entry_t out_c;

   // Handshake decode: ready depends only on registered occupancy.
   always_comb begin
      fetch_ready_c = (count_q < CW'(DEPTH));
      head_valid_c  = (count_q != '0);
      in_c.pc       = bus.fetch_pc_i;
      in_c.instr    = bus.fetch_instr_i;
      in_c.misalign = |bus.fetch_pc_i[1:0];
      dec_valid_c   = head_valid_c;
      out_c         = head_valid_c ? mem_q[rd_ptr_q] : '0;
      push_c        = bus.fetch_valid_i && fetch_ready_c && !bus.flush_i;
      pop_c         = head_valid_c && bus.dec_ready_i && !bus.flush_i;
`ifdef FETCHQ_BYPASS_EN
      // Empty queue: show the incoming entry directly; consume it without storing.
      if (!head_valid_c && bus.fetch_valid_i && !bus.flush_i) begin
         dec_valid_c = 1'b1;
         out_c       = in_c;
         if (bus.dec_ready_i) begin
            push_c = 1'b0;
         end
      end
`endif
   end

   // Next-state for pointers and occupancy; flush overrides everything.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push_c && !pop_c) begin
            count_d = count_q + CW'(1);
         end else if (pop_c && !push_c) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   // Control state registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are masked by count so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= in_c;
      end
   end

   assign bus.fetch_ready_o  = fetch_ready_c;
   assign bus.dec_valid_o    = dec_valid_c;
   assign bus.dec_pc_o       = out_c.pc;
   assign bus.dec_instr_o    = out_c.instr;
   assign bus.dec_misalign_o = out_c.misalign;
   assign bus.count_o        = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_fetch_queue;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t q[$];

   fetch_queue_if #(.DEPTH(DEPTH)) bus ();

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare all outputs against the model's view of the current cycle.
   task automatic check_outs();
      logic ev;
      ent_t eh;
      ev = (q.size() != 0);
      eh.pc = 32'h0;
      eh.instr = 32'h0;
      if (ev) eh = q[0];
`ifdef FETCHQ_BYPASS_EN
      if (!ev && bus.fetch_valid_i === 1'b1 && bus.flush_i === 1'b0) begin
         ev = 1'b1;
         eh.pc = bus.fetch_pc_i;
         eh.instr = bus.fetch_instr_i;
      end
`endif
      chk("dec_valid", 32'(bus.dec_valid_o), 32'(ev));
      chk("dec_pc", bus.dec_pc_o, eh.pc);
      chk("dec_instr", bus.dec_instr_o, eh.instr);
      chk("dec_misalign", 32'(bus.dec_misalign_o), 32'(|eh.pc[1:0]));
      chk("count", 32'(bus.count_o), 32'(q.size()));
      chk("fetch_ready", 32'(bus.fetch_ready_o), 32'(q.size() < DEPTH));
   endtask

   // One cycle: drive after falling edge, check, advance model at rising edge.
   task automatic step(input logic fl, input logic v, input logic [31:0] pc,
                       input logic [31:0] instr, input logic rdy);
      int   n;
      logic push;
      logic pop;
      ent_t e;
      bus.flush_i       = fl;
      bus.fetch_valid_i = v;
      bus.fetch_pc_i    = pc;
      bus.fetch_instr_i = instr;
      bus.dec_ready_i   = rdy;
      #1;
      check_outs();
      n    = q.size();
      push = v && (n < DEPTH) && !fl;
      pop  = (n != 0) && rdy && !fl;
`ifdef FETCHQ_BYPASS_EN
      if (n == 0 && v && rdy && !fl) push = 1'b0;
`endif
      e.pc = pc;
      e.instr = instr;
      if (fl) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      bus.flush_i       = 1'b0;
      bus.fetch_valid_i = 1'b0;
      bus.fetch_pc_i    = 32'h0;
      bus.fetch_instr_i = 32'h0;
      bus.dec_ready_i   = 1'b0;

      // Reset values
      #2;
      check_outs();
      @(negedge clk);
      rst_n = 1'b1;

      // Single push, visible next cycle
      step(1'b0, 1'b1, 32'h0000_0000, 32'h0050_0093, 1'b0);
      idle();
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

      // Fill to full, refused fifth push, drain in order
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0);
      step(1'b0, 1'b1, 32'h10, 32'h2000, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      idle();

      // Simultaneous push/pop at count 2 across pointer wrap
      step(1'b0, 1'b1, 32'h0, 32'h3000, 1'b0);
      step(1'b0, 1'b1, 32'h4, 32'h3001, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h8 + 32'(i * 4), 32'h3002 + 32'(i), 1'b1);
      idle();

      // Flush with a same-cycle push
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h100 + 32'(i * 4), 32'h4000 + 32'(i), 1'b0);
      step(1'b1, 1'b1, 32'h40, 32'h4444, 1'b0);
      idle();
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

      // Misaligned PC
      step(1'b0, 1'b1, 32'h0000_0006, 32'h5000, 1'b0);
      idle();
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

      // Empty queue push with decode ready (bypass when enabled)
      step(1'b0, 1'b1, 32'h20, 32'h6000, 1'b1);
      idle();
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

      // Asynchronous reset between edges with two entries held
      step(1'b0, 1'b1, 32'h200, 32'h7000, 1'b0);
      step(1'b0, 1'b1, 32'h204, 32'h7001, 1'b0);
      bus.fetch_valid_i = 1'b0;
      bus.dec_ready_i   = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      check_outs();
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      idle();

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(15) == 0),
              ($urandom_range(9) < 7),
              $urandom,
              $urandom,
              ($urandom_range(9) < 6));
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the program counter / instruction memory and the decode stage of the pipelined core. It captures each fetched {PC, instruction} pair, buffers up to DEPTH entries, and presents them in order to decode with a valid/ready handshake. It back-pressures the PC register through `fetch_ready_o`, which the PC update logic uses as its enable. It supports a single-cycle flush for branch and jump redirects.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥ 2
- `clk_i`  in  1  clock, all state updates on rising edge
- `rst_ni`  in  1  reset, asynchronous assert, active-low
- `flush_i`  in  1  discard all buffered entries and any same-cycle push
- `fetch_valid_i`  in  1  fetch side presents an entry this cycle
- `fetch_pc_i`  in  32  PC of the fetched instruction (the PC register output)
- `fetch_instr_i`  in  32  instruction word read at `fetch_pc_i`
- `fetch_ready_o`  out  1  queue accepts a push this cycle; PC must hold when low
- `dec_valid_o`  out  1  head entry valid
- `dec_pc_o`  out  32  head PC
- `dec_instr_o`  out  32  head instruction
- `dec_misalign_o`  out  1  head PC had bits [1:0] ≠ 0
- `dec_ready_i`  in  1  decode consumes the head this cycle
- `count_o`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage is a circular buffer with read pointer, write pointer and count registers. Pointers wrap modulo DEPTH.
- Push occurs when `fetch_valid_i && fetch_ready_o && !flush_i`.
  - Stores `fetch_pc_i`, `fetch_instr_i`, and `misalign = |fetch_pc_i[1:0]`.
  - Write pointer advances by 1.
- Pop occurs when `dec_valid_o && dec_ready_i && !flush_i`. Read pointer advances by 1.
- `fetch_ready_o = (count < DEPTH)`. It depends only on registered state, so there is no combinational path from `dec_ready_i`.
  - When full, a push is refused even if a pop happens in the same cycle.
- `dec_valid_o = (count != 0)`. The `dec_*` data outputs show the entry at the read pointer.
  - While `dec_valid_o` is 0, the data outputs are 0.
- Count update on each edge:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - neither: unchanged
- Flush takes priority over everything else. On the next edge, count, read pointer and write pointer all become 0, and any same-cycle push or pop is dropped.
- A pop while empty and a push while full are impossible by construction; both are ignored.
- Entries flagged misaligned are queued normally. Decode handles the exception.

## Timing
- Reset (`rst_ni` = 0, asynchronous) sets the following immediately, without waiting for a clock edge:
  - count = 0, pointers = 0
  - `dec_valid_o` = 0, `dec_pc_o` = 0, `dec_instr_o` = 0, `dec_misalign_o` = 0
  - `count_o` = 0, `fetch_ready_o` = 1
- Reset asserted mid-operation discards all entries. Storage contents are don't-care because they are masked by count.
- Push-to-output latency (default build): an entry pushed at edge N is visible at `dec_*` in the cycle after edge N.
- Throughput is 1 push and 1 pop per cycle while 0 < count < DEPTH.
- A flush asserted in cycle N gives `dec_valid_o` = 0 and `fetch_ready_o` = 1 in cycle N+1.

## Configuration
- `FETCHQ_BYPASS_EN`:
  - **Defined:**
    - When count = 0 and `fetch_valid_i` = 1, the `dec_*` outputs show the incoming entry combinationally and `dec_valid_o` = 1.
    - If `dec_ready_i` = 1 in that cycle, the entry is consumed and not stored: count stays 0.
    - If `dec_ready_i` = 0, the entry is stored as a normal push.
    - `flush_i` suppresses the bypass: `dec_valid_o` = 0.
  - **Undefined:** no bypass; minimum latency is 1 cycle as described in Timing.

## Test plan
- **Reset then single push:** `rst_ni` = 0 → all outputs 0 and `fetch_ready_o` = 1. After release, push PC=0x00000000, instr=0x00500093 → next cycle `dec_valid_o` = 1, `dec_pc_o` = 0x0, `dec_instr_o` = 0x00500093, `count_o` = 1.
- **Fill to full:** `dec_ready_i` = 0, push PCs 0x0, 0x4, 0x8, 0xC → `count_o` = 4 and `fetch_ready_o` = 0. A fifth push with PC 0x10 is ignored. Then drain with `dec_ready_i` = 1 → outputs 0x0, 0x4, 0x8, 0xC in order, then `dec_valid_o` = 0.
- **Simultaneous push/pop at count 2:** `count_o` stays 2 and the head advances 0x0 → 0x4. Continue 8 cycles → pointers wrap and order is preserved.
- **Flush with push in same cycle:** count = 3, assert `flush_i` together with a push of PC 0x40 → next cycle `count_o` = 0 and `dec_valid_o` = 0. PC 0x40 never appears at the output.
- **Misaligned PC:** push PC 0x00000006 → at the head, `dec_misalign_o` = 1 and `dec_pc_o` = 0x6.
- **Async reset mid-stream:** with count = 2, pulse `rst_ni` low between clock edges → outputs go to reset values before the next edge.
- **Bypass** (`FETCHQ_BYPASS_EN` defined): empty queue, push PC 0x20 with `dec_ready_i` = 1 → same cycle `dec_valid_o` = 1 and `dec_pc_o` = 0x20; next cycle `count_o` = 0.
